// File: rtl/axi_sdram_r_chn.sv
// ---------------------------------------------------------------------------
// axi_sdram_r_chn
//   Bridges the SDRAM controller read-data stream onto an AXI slave R channel.
//   Beats are counted against the arlen of the oldest outstanding burst, taken
//   from a first-word-fall-through burst-message FIFO. The count decides where
//   rlast falls and when that message is popped. A 2-entry skid buffer
//   decouples the stream from s_axi_rready, so the input ready never depends
//   combinationally on the AXI master, and 1 beat/clk is sustained.
//
// Parameters
//   EN_LEN_CHECK : 1 = flag SDRAM-side last markers that disagree with the
//                  arlen-derived end of burst (sticky rd_len_err); 0 = off.
//
// Ports
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   s_axis_rd_data/last/valid  : read beats from the SDRAM controller
//   s_axis_rd_ready            : beat accepted this cycle when valid is high
//   rd_burst_msg_fifo_dout     : arlen of the oldest outstanding burst
//   rd_burst_msg_fifo_empty_n  : burst-message FIFO holds at least one entry
//   rd_burst_msg_fifo_ren      : pops the burst message on its last beat
//   s_axi_r*                   : AXI slave R channel (rresp always OKAY)
//   rd_len_err                 : sticky length-mismatch flag
// ---------------------------------------------------------------------------
module axi_sdram_r_chn #(
  parameter int EN_LEN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_rd_data,
  input  logic        s_axis_rd_last,
  input  logic        s_axis_rd_valid,
  output logic        s_axis_rd_ready,
  input  logic [7:0]  rd_burst_msg_fifo_dout,
  input  logic        rd_burst_msg_fifo_empty_n,
  output logic        rd_burst_msg_fifo_ren,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        rd_len_err
);

  logic [7:0]  cnt_r;
  logic [31:0] buf_data_r [2];
  logic [1:0]  buf_last_r;
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  occ_r;
  logic        len_err_r;

  logic        is_last_s;
  logic        push_s;
  logic        pop_s;

  // End of burst is decided by the count alone; the SDRAM last marker is
  // only cross-checked, never trusted.
  assign is_last_s = (cnt_r == rd_burst_msg_fifo_dout);

  // Accept only when a burst is known, so a beat can never arrive without
  // an arlen to count it against. Depends on registered occupancy only.
  assign s_axis_rd_ready = (occ_r != 2'd2) & rd_burst_msg_fifo_empty_n;
  assign push_s          = s_axis_rd_valid & s_axis_rd_ready;
  assign pop_s           = (occ_r != 2'd0) & s_axi_rready;

  // Message pop coincides with the accepted last beat, which already
  // requires empty_n, so an empty FIFO is never popped.
  assign rd_burst_msg_fifo_ren = push_s & is_last_s;

  assign s_axi_rvalid = (occ_r != 2'd0);
  assign s_axi_rdata  = buf_data_r[rd_ptr_r];
  assign s_axi_rlast  = buf_last_r[rd_ptr_r];
  assign s_axi_rresp  = 2'b00;
  assign rd_len_err   = len_err_r;

  // Beat counter within the current burst; wraps to 0 after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (push_s) begin
      if (is_last_s) begin
        cnt_r <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Buffer write side: store {data, last} at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_r[i] <= 32'd0;
      end
      buf_last_r <= 2'b00;
      wr_ptr_r   <= 1'b0;
    end else if (push_s) begin
      buf_data_r[wr_ptr_r] <= s_axis_rd_data;
      buf_last_r[wr_ptr_r] <= is_last_s;
      wr_ptr_r             <= ~wr_ptr_r;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Buffer read side: advance the head on an R handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= 1'b0;
    end else if (pop_s) begin
      rd_ptr_r <= ~rd_ptr_r;
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  generate
    if (EN_LEN_CHECK != 0) begin : g_len_check
      // Sticky mismatch between the SDRAM last marker and the counted end.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          len_err_r <= 1'b0;
        end else if (push_s && (s_axis_rd_last != is_last_s)) begin
          len_err_r <= 1'b1;
        end else begin
          len_err_r <= len_err_r;
        end
      end
    end else begin : g_no_len_check
      assign len_err_r = 1'b0;
    end
  endgenerate

endmodule

// File: doc/axi_sdram_r_chn.md
AXI_SDRAM_R_CHN -- requirements
Module: axi_sdram_r_chn

Interface
REQ-001 SHALL have parameter: EN_LEN_CHECK, default 1, enables the SDRAM-last vs. AXI-burst-length consistency check.
REQ-002 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_axis_rd_data  input  32  read data beat from the SDRAM controller.
REQ-005 SHALL have port s_axis_rd_last  input  1  SDRAM-side end-of-burst marker.
REQ-006 SHALL have port s_axis_rd_valid  input  1  read data valid.
REQ-007 SHALL have port s_axis_rd_ready  output  1  read data accepted.
REQ-008 SHALL have port rd_burst_msg_fifo_dout  input  8  arlen of the oldest outstanding read burst (first-word-fall-through FIFO).
REQ-009 SHALL have port rd_burst_msg_fifo_empty_n  input  1  burst-message FIFO not empty.
REQ-010 SHALL have port rd_burst_msg_fifo_ren  output  1  pops one burst message.
REQ-011 SHALL have ports s_axi_rdata output 32, s_axi_rresp output 2, s_axi_rlast output 1, s_axi_rvalid output 1, s_axi_rready input 1: AXI slave R channel.
REQ-012 SHALL have port rd_len_err  output  1  sticky length-mismatch flag.

Function
REQ-013 SHALL hold beat counter cnt[7:0]; current beat is last of burst when cnt == rd_burst_msg_fifo_dout.
REQ-014 SHALL buffer beats in a 2-entry FIFO holding {data[31:0], last}, with write/read pointers and occupancy 0..2.
REQ-015 SHALL drive s_axis_rd_ready = (occupancy != 2) & rd_burst_msg_fifo_empty_n; not dependent on s_axi_rready in the same cycle.
REQ-016 SHALL accept an input beat when s_axis_rd_valid & s_axis_rd_ready; this pushes {s_axis_rd_data, cnt == dout} into the buffer.
REQ-017 On accepted beat with cnt == dout: SHALL set cnt <= 0 and assert rd_burst_msg_fifo_ren for exactly that cycle; otherwise cnt <= cnt + 1.
REQ-018 SHALL NOT assert rd_burst_msg_fifo_ren in any other cycle; never while empty_n = 0.
REQ-019 SHALL drive s_axi_rvalid = (occupancy != 0); s_axi_rdata/s_axi_rlast from head entry; s_axi_rresp constant 2'b00.
REQ-020 SHALL pop the head entry on s_axi_rvalid & s_axi_rready.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; push at occupancy 2 is impossible by REQ-015.
REQ-022 Latency: a beat accepted at edge N SHALL be visible on s_axi_rvalid in the cycle after edge N; with s_axi_rready held 1, sustained throughput SHALL be 1 beat/clk.
REQ-023 SHALL preserve beat order and data exactly; pointers wrap modulo 2.
REQ-024 With EN_LEN_CHECK = 1: on an accepted beat where s_axis_rd_last != (cnt == dout), rd_len_err SHALL set to 1 at the next edge and hold until reset; AXI rlast still follows cnt. With EN_LEN_CHECK = 0: rd_len_err SHALL be constant 0.
REQ-025 arlen = 255 SHALL produce 256 beats; cnt SHALL not overflow past dout.
REQ-026 Burst boundaries SHALL not insert bubbles: the first beat of the next burst is accepted in the cycle after the previous last beat if the FIFO is still non-empty.

Reset
REQ-027 On rst_n low, asynchronously: cnt = 0, occupancy = 0, pointers = 0, buffer entries = 0, rd_len_err = 0.
REQ-028 During and immediately after reset: s_axi_rvalid = 0, s_axi_rlast = 0, s_axi_rdata = 0, s_axi_rresp = 2'b00, rd_burst_msg_fifo_ren = 0; s_axis_rd_ready = rd_burst_msg_fifo_empty_n.
REQ-029 Reset mid-burst SHALL discard buffered beats and partial count; no message pop occurs for the aborted burst.

Verification
REQ-030 arlen = 0, one beat 0xA5A5_0001 with rd_last = 1, rready = 1 -> one R beat, rlast = 1, rresp = 0, ren pulses once, rd_len_err = 0.
REQ-031 arlen = 3 then arlen = 1 queued, 6 beats streamed back-to-back, rready = 1 -> 6 contiguous R beats, rlast on beats 4 and 6, two ren pulses, no bubble.
REQ-032 arlen = 7, rready = 0 for 10 cycles -> exactly 2 beats accepted, s_axis_rd_ready = 0; release rready -> all 8 beats in order, data intact.
REQ-033 Message FIFO empty, s_axis_rd_valid = 1 -> s_axis_rd_ready = 0, no R beats, no ren.
REQ-034 arlen = 3, rd_last asserted on beat 2 -> rd_len_err = 1 after that edge and sticky; rlast still on beat 4.
REQ-035 Reset asserted after beat 2 of arlen = 3 -> rvalid = 0, cnt = 0 immediately; new arlen = 0 burst then completes correctly.
